// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: two-player match sequencer for the Pong game.
// Controls the graph unit (gra_still, launch, serve_dir), the 2-second timer
// (timer_start / timer_up) and the two BCD score counters through the phases
// IDLE, SERVE, PLAY, POINT, PAUSE and OVER.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   btn_start, btn_pause  debounced button levels (rising edge = event)
//   hit, miss_l, miss_r   one-cycle pulses from the graph unit
//   timer_up              level from the 2-second timer
//   gra_still             1 freezes the graph animation
//   launch, timer_start   one-cycle pulses
//   serve_dir             0 = launch toward right, 1 = toward left
//   score_l, score_r      two-digit BCD scores
//   rally                 hits since last launch (saturating)
//   winner                00 none, 01 left, 10 right
//   state                 phase code for the text/RGB multiplexer
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE = 11,
   parameter int unsigned RALLY_MAX = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       hit,
   input  logic       miss_l,
   input  logic       miss_r,
   input  logic       timer_up,
   output logic       gra_still,
   output logic       launch,
   output logic       serve_dir,
   output logic       timer_start,
   output logic [7:0] score_l,
   output logic [7:0] score_r,
   output logic [7:0] rally,
   output logic [1:0] winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StPause = 3'd4,
      StOver  = 3'd5
   } st_e;

   // Winning score in BCD, fixed at elaboration.
   localparam logic [7:0] WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
   localparam logic [7:0] RALLY_SAT = 8'(RALLY_MAX);

   st_e  st_q;
   logic start_prev_q, pause_prev_q;
   logic start_ev, pause_ev;
   logic [7:0] score_l_inc, score_r_inc;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   assign start_ev    = btn_start & ~start_prev_q;
   assign pause_ev    = btn_pause & ~pause_prev_q;
   assign score_l_inc = bcd_inc(score_l);
   assign score_r_inc = bcd_inc(score_r);
   assign state       = st_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q         <= StIdle;
         // Previous values start high so a button held through reset is no event.
         start_prev_q <= 1'b1;
         pause_prev_q <= 1'b1;
         gra_still    <= 1'b1;
         launch       <= 1'b0;
         timer_start  <= 1'b0;
         serve_dir    <= 1'b0;
         score_l      <= 8'h00;
         score_r      <= 8'h00;
         rally        <= 8'd0;
         winner       <= 2'b00;
      end else begin
         start_prev_q <= btn_start;
         pause_prev_q <= btn_pause;
         launch       <= 1'b0;
         timer_start  <= 1'b0;
         unique case (st_q)
            StIdle: begin
               if (start_ev) begin
                  score_l   <= 8'h00;
                  score_r   <= 8'h00;
                  winner    <= 2'b00;
                  rally     <= 8'd0;
                  serve_dir <= 1'b0;
                  st_q      <= StServe;
               end
            end
            StServe: begin
               if (start_ev) begin
                  launch    <= 1'b1;
                  rally     <= 8'd0;
                  gra_still <= 1'b0;
                  st_q      <= StPlay;
               end
            end
            StPlay: begin
               // Misses take priority over hit and pause in the same cycle.
               if (miss_l && miss_r) begin
                  timer_start <= 1'b1;
                  gra_still   <= 1'b1;
                  st_q        <= StPoint;
               end else if (miss_l) begin
                  score_r     <= score_r_inc;
                  serve_dir   <= 1'b1;
                  timer_start <= 1'b1;
                  gra_still   <= 1'b1;
                  if (score_r_inc == WIN_BCD) begin
                     winner <= 2'b10;
                     st_q   <= StOver;
                  end else begin
                     st_q   <= StPoint;
                  end
               end else if (miss_r) begin
                  score_l     <= score_l_inc;
                  serve_dir   <= 1'b0;
                  timer_start <= 1'b1;
                  gra_still   <= 1'b1;
                  if (score_l_inc == WIN_BCD) begin
                     winner <= 2'b01;
                     st_q   <= StOver;
                  end else begin
                     st_q   <= StPoint;
                  end
               end else begin
                  if (hit && rally != RALLY_SAT) begin
                     rally <= rally + 8'd1;
                  end
                  if (pause_ev) begin
                     gra_still <= 1'b1;
                     st_q      <= StPause;
                  end
               end
            end
            StPause: begin
               if (pause_ev) begin
                  gra_still <= 1'b0;
                  st_q      <= StPlay;
               end
            end
            StPoint: begin
               // timer_start high marks the entry cycle; a stale timer_up is ignored.
               if (timer_up && !timer_start) begin
                  st_q <= StServe;
               end
            end
            StOver: begin
               if (timer_up && !timer_start) begin
                  st_q <= StIdle;
               end
            end
            default: begin
               gra_still <= 1'b1;
               st_q      <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl (default parameters).
module tb_pong_match_ctrl;

   logic       clk = 1'b0;
   logic       reset, btn_start, btn_pause, hit, miss_l, miss_r, timer_up;
   logic       gra_still, launch, serve_dir, timer_start;
   logic [7:0] score_l, score_r, rally;
   logic [1:0] winner;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   pong_match_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .btn_start   (btn_start),
      .btn_pause   (btn_pause),
      .hit         (hit),
      .miss_l      (miss_l),
      .miss_r      (miss_r),
      .timer_up    (timer_up),
      .gra_still   (gra_still),
      .launch      (launch),
      .serve_dir   (serve_dir),
      .timer_start (timer_start),
      .score_l     (score_l),
      .score_r     (score_r),
      .rally       (rally),
      .winner      (winner),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start-button event from SERVE (or IDLE): press one cycle, release one cycle.
   task automatic press_start();
      btn_start = 1'b1; tick();
      btn_start = 1'b0; tick();
   endtask

   // From PLAY: miss pulse, wait out POINT, serve again back into PLAY.
   task automatic play_point(input logic l, input logic r);
      miss_l = l; miss_r = r; tick();
      miss_l = 1'b0; miss_r = 1'b0;
      timer_up = 1'b1; tick(); tick();
      timer_up = 1'b0;
      press_start();
   endtask

   initial begin
      reset = 1'b1; btn_start = 1'b1; btn_pause = 1'b0; hit = 1'b0;
      miss_l = 1'b0; miss_r = 1'b0; timer_up = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_still", 32'(gra_still), 32'd1);
      chk("rst_launch", 32'(launch), 32'd0);
      chk("rst_tstart", 32'(timer_start), 32'd0);
      chk("rst_dir", 32'(serve_dir), 32'd0);
      chk("rst_scores", {16'd0, score_l, score_r}, 32'h0000);
      chk("rst_rally", 32'(rally), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      // Start held through reset is not an event.
      tick();
      chk("held_start_no_event", 32'(state), 32'd0);
      btn_start = 1'b0; tick();

      // 1: IDLE -> SERVE -> PLAY
      btn_start = 1'b1; tick();
      chk("idle_to_serve", 32'(state), 32'd1);
      chk("serve_still", 32'(gra_still), 32'd1);
      btn_start = 1'b0; tick();
      btn_start = 1'b1; tick();
      chk("serve_to_play", 32'(state), 32'd2);
      chk("launch_pulse", 32'(launch), 32'd1);
      chk("launch_dir", 32'(serve_dir), 32'd0);
      chk("play_still", 32'(gra_still), 32'd0);
      btn_start = 1'b0; tick();
      chk("launch_one_cycle", 32'(launch), 32'd0);

      // 2: score_l to 09, then miss_r gives BCD carry to 10
      for (int i = 0; i < 9; i++) play_point(1'b0, 1'b1);
      chk("score_l_09", 32'(score_l), 32'h09);
      miss_r = 1'b1; tick(); miss_r = 1'b0;
      chk("score_l_10", 32'(score_l), 32'h10);
      chk("miss_r_dir", 32'(serve_dir), 32'd0);
      chk("miss_r_tstart", 32'(timer_start), 32'd1);
      chk("miss_r_state", 32'(state), 32'd3);
      timer_up = 1'b1; tick();
      chk("point_retrigger_ignored", 32'(state), 32'd3);
      chk("tstart_one_cycle", 32'(timer_start), 32'd0);
      tick();
      chk("point_to_serve", 32'(state), 32'd1);
      timer_up = 1'b0;
      press_start();

      // 3: simultaneous misses replay the point
      miss_l = 1'b1; miss_r = 1'b1; tick(); miss_l = 1'b0; miss_r = 1'b0;
      chk("replay_state", 32'(state), 32'd3);
      chk("replay_scores", {16'd0, score_l, score_r}, 32'h1000);
      chk("replay_tstart", 32'(timer_start), 32'd1);
      tick();
      chk("replay_tstart_once", 32'(timer_start), 32'd0);
      timer_up = 1'b1; tick(); timer_up = 1'b0;
      press_start();

      // 5: pause ignores misses and hits; held pause toggles once
      hit = 1'b1; tick(); tick(); tick(); hit = 1'b0;
      chk("rally_3", 32'(rally), 32'd3);
      btn_pause = 1'b1; tick();
      chk("pause_state", 32'(state), 32'd4);
      chk("pause_still", 32'(gra_still), 32'd1);
      btn_pause = 1'b0;
      miss_l = 1'b1; tick(); miss_l = 1'b0;
      hit = 1'b1; tick(); tick(); tick(); hit = 1'b0;
      chk("pause_hold_state", 32'(state), 32'd4);
      chk("pause_hold_rally", 32'(rally), 32'd3);
      chk("pause_hold_scores", {16'd0, score_l, score_r}, 32'h1000);
      btn_pause = 1'b1; tick();
      chk("unpause_state", 32'(state), 32'd2);
      for (int i = 0; i < 9; i++) tick();
      chk("held_pause_one_toggle", 32'(state), 32'd2);
      chk("unpause_rally", 32'(rally), 32'd3);
      btn_pause = 1'b0; tick();

      // 4: right player reaches 11 and wins
      for (int i = 0; i < 10; i++) play_point(1'b1, 1'b0);
      chk("score_r_10", 32'(score_r), 32'h10);
      chk("miss_l_dir", 32'(serve_dir), 32'd1);
      miss_l = 1'b1; tick(); miss_l = 1'b0;
      chk("win_score_r", 32'(score_r), 32'h11);
      chk("win_winner", 32'(winner), 32'd2);
      chk("win_state", 32'(state), 32'd5);
      chk("win_tstart", 32'(timer_start), 32'd1);
      timer_up = 1'b1; tick();
      chk("over_retrigger_ignored", 32'(state), 32'd5);
      tick(); timer_up = 1'b0;
      chk("over_to_idle", 32'(state), 32'd0);
      chk("idle_winner_held", 32'(winner), 32'd2);
      chk("idle_scores_held", {16'd0, score_l, score_r}, 32'h1011);
      btn_start = 1'b1; tick(); btn_start = 1'b0;
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_scores", {16'd0, score_l, score_r}, 32'h0000);
      chk("restart_winner", 32'(winner), 32'd0);
      chk("restart_dir", 32'(serve_dir), 32'd0);
      tick();

      // 6: rally saturation, miss beats pause, reset mid-play
      press_start();
      hit = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      hit = 1'b0;
      chk("rally_sat", 32'(rally), 32'd255);
      btn_pause = 1'b1; miss_r = 1'b1; tick(); miss_r = 1'b0; btn_pause = 1'b0;
      chk("miss_beats_pause", 32'(state), 32'd3);
      chk("miss_beats_pause_score", 32'(score_l), 32'h01);
      timer_up = 1'b1; tick(); tick(); timer_up = 1'b0;
      press_start();
      hit = 1'b1; tick(); tick(); hit = 1'b0;
      reset = 1'b1; btn_start = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_still", 32'(gra_still), 32'd1);
      chk("mid_rst_outs", {28'd0, launch, timer_start, serve_dir, 1'b0}, 32'd0);
      chk("mid_rst_scores", {16'd0, score_l, score_r}, 32'h0000);
      chk("mid_rst_rally", 32'(rally), 32'd0);
      chk("mid_rst_winner", 32'(winner), 32'd0);
      tick();
      chk("mid_rst_held_start", 32'(state), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
